muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 118 +++++++++++
 tb/tb_muldiv_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencing FSM: hands operands to external mul/div units,
// stalls the pipeline while they work and writes the result to HI/LO once.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        stall_req,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_op1,
  output logic [31:0] mul_op2,
  input  logic        mul_ready,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY, DONE} state_e;

  state_e      state_q;
  logic        sgn_q;
  logic [31:0] src1_q, src2_q;
  logic [31:0] hi_q, lo_q;
  logic [5:0]  wdog_q;
  logic        timeout_q;

  logic        mul_busy, div_busy, done;
  logic        unit_ready;
  logic [63:0] unit_res;
  logic [5:0]  wdog_d;

  assign mul_busy   = (state_q == MUL_BUSY);
  assign div_busy   = (state_q == DIV_BUSY);
  assign done       = (state_q == DONE);
  assign unit_ready = mul_busy ? mul_ready : div_ready;
  assign unit_res   = mul_busy ? mul_result : div_result;
  assign wdog_d     = (wdog_q == 6'h3f) ? wdog_q : wdog_q + 6'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      sgn_q     <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && !flush) begin
            sgn_q  <= ~req_op[0];
            src1_q <= req_src1;
            src2_q <= req_src2;
            wdog_q <= '0;
            if (!req_op[1]) begin
              state_q <= MUL_BUSY;
            end else if (req_src2 != 32'd0) begin
              state_q <= DIV_BUSY;
            end else begin
              // Divide by zero never reaches the divider: fixed HI/LO result.
              hi_q    <= req_src1;
              lo_q    <= 32'hFFFF_FFFF;
              state_q <= DONE;
            end
          end
        end
        MUL_BUSY, DIV_BUSY: begin
          wdog_q <= wdog_d;
          if (flush) begin
            state_q <= IDLE;
          end else if (unit_ready) begin
            {hi_q, lo_q} <= unit_res;
            state_q      <= DONE;
          end else if (wdog_d == 6'h3f) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign stall_req   = (state_q == IDLE && req_valid && !flush) || mul_busy || div_busy;
  assign mul_start   = mul_busy;
  assign mul_signed  = mul_busy & sgn_q;
  assign mul_op1     = mul_busy ? src1_q : 32'd0;
  assign mul_op2     = mul_busy ? src2_q : 32'd0;
  assign div_start   = div_busy;
  assign div_signed  = div_busy & sgn_q;
  assign div_annul   = div_busy & flush;
  assign div_op1     = div_busy ? src1_q : 32'd0;
  assign div_op2     = div_busy ? src2_q : 32'd0;
  assign hilo_we     = done & ~flush;
  assign hi_wdata    = done ? hi_q : 32'd0;
  assign lo_wdata    = done ? lo_q : 32'd0;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed corner cases plus randomized operations,
// acting as the mul/div units and checking against an arithmetic model.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, flush, mul_ready, div_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic [63:0] mul_result, div_result;
  logic        stall_req, mul_start, mul_signed, div_start, div_signed, div_annul;
  logic [31:0] mul_op1, mul_op2, div_op1, div_op2, hi_wdata, lo_wdata;
  logic        hilo_we, busy, timeout_err;

  int   n_chk = 0;
  int   n_err = 0;
  logic exp_to;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush), .stall_req(stall_req),
    .mul_start(mul_start), .mul_signed(mul_signed), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_ready(mul_ready), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
    .div_op1(div_op1), .div_op2(div_op2), .div_ready(div_ready), .div_result(div_result),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // MIPS HI/LO semantics: products {hi,lo}; quotients {remainder,quotient}.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] s1,
                                             input logic [31:0] s2);
    longint a, b;
    int     q, r;
    case (op)
      2'b00: begin a = $signed(s1); b = $signed(s2); return a * b; end
      2'b01: return {32'd0, s1} * {32'd0, s2};
      2'b10: begin
        if (s2 == 32'd0) return {s1, 32'hFFFF_FFFF};
        q = $signed(s1) / $signed(s2);
        r = $signed(s1) % $signed(s2);
        return {r, q};
      end
      default: begin
        if (s2 == 32'd0) return {s1, 32'hFFFF_FFFF};
        return {s1 % s2, s1 / s2};
      end
    endcase
  endfunction

  // lat: busy cycle in which ready is raised; fl: busy cycle carrying flush (0 = none).
  task automatic do_op(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input int lat, input int fl, input logic fl_rdy, input logic fl_done);
    logic [63:0] exp;
    logic        is_div, dz, sgn, wr, fin;
    int          c;
    exp        = ref_result(op, s1, s2);
    is_div     = op[1];
    dz         = is_div && (s2 == 32'd0);
    sgn        = ~op[0];
    mul_result = is_div ? 64'd0 : exp;
    div_result = is_div ? exp : 64'd0;
    req_valid  = 1'b1;
    req_op     = op;
    req_src1   = s1;
    req_src2   = s2;
    flush      = 1'b0;
    #1 chk("stall_on_request", 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    wr = 1'b1;
    if (!dz) begin
      fin = 1'b0;
      c   = 1;
      while (!fin) begin
        chk("busy", 64'(busy), 64'd1);
        chk("stall_busy", 64'(stall_req), 64'd1);
        chk("we_busy", 64'(hilo_we), 64'd0);
        chk("mul_start", 64'(mul_start), 64'(!is_div));
        chk("div_start", 64'(div_start), 64'(is_div));
        if (is_div) begin
          chk("div_signed", 64'(div_signed), 64'(sgn));
          chk("div_op1", 64'(div_op1), 64'(s1));
          chk("div_op2", 64'(div_op2), 64'(s2));
        end else begin
          chk("mul_signed", 64'(mul_signed), 64'(sgn));
          chk("mul_op1", 64'(mul_op1), 64'(s1));
          chk("mul_op2", 64'(mul_op2), 64'(s2));
        end
        mul_ready = !is_div && (c == lat || (c == fl && fl_rdy));
        div_ready =  is_div && (c == lat || (c == fl && fl_rdy));
        if (c == fl) begin
          flush = 1'b1;
          #1 chk("div_annul", 64'(div_annul), 64'(is_div));
        end else begin
          chk("div_annul_quiet", 64'(div_annul), 64'd0);
        end
        @(posedge clk); #1;
        mul_ready = 1'b0;
        div_ready = 1'b0;
        if (c == fl) begin
          flush = 1'b0; req_valid = 1'b0; wr = 1'b0; fin = 1'b1;
          #1;
          chk("busy_after_flush", 64'(busy), 64'd0);
          chk("we_after_flush", 64'(hilo_we), 64'd0);
        end else if (c == lat) begin
          fin = 1'b1;
        end else if (c == 63) begin
          req_valid = 1'b0; wr = 1'b0; fin = 1'b1; exp_to = 1'b1;
          #1;
          chk("timeout_err_set", 64'(timeout_err), 64'd1);
          chk("busy_after_timeout", 64'(busy), 64'd0);
          chk("stall_after_timeout", 64'(stall_req), 64'd0);
          chk("we_after_timeout", 64'(hilo_we), 64'd0);
        end
        c++;
      end
    end
    if (wr) begin
      flush = fl_done;
      #1;
      chk("hilo_we_done", 64'(hilo_we), 64'(!fl_done));
      chk("stall_done", 64'(stall_req), 64'd0);
      chk("mul_start_done", 64'(mul_start), 64'd0);
      chk("div_start_done", 64'(div_start), 64'd0);
      if (!fl_done) begin
        chk("hi_wdata", 64'(hi_wdata), 64'(exp[63:32]));
        chk("lo_wdata", 64'(lo_wdata), 64'(exp[31:0]));
      end
      @(posedge clk); #1;
      flush = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("idle_after_done", 64'(busy), 64'd0);
      chk("we_after_done", 64'(hilo_we), 64'd0);
    end
    chk("timeout_sticky", 64'(timeout_err), 64'(exp_to));
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] s1, s2;
    int          lat, fl;

    resetn = 1'b0; req_valid = 1'b0; flush = 1'b0; mul_ready = 1'b0; div_ready = 1'b0;
    req_op = 2'b00; req_src1 = '0; req_src2 = '0; mul_result = '0; div_result = '0;
    exp_to = 1'b0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_we", 64'(hilo_we), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    chk("rst_starts", 64'({mul_start, div_start}), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, 32, 0, 1'b0, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 33, 0, 1'b0, 1'b0);
    do_op(2'b10, 32'h1234, 32'd0, 1, 0, 1'b0, 1'b0);
    do_op(2'b10, 32'd500, 32'd9, 100, 10, 1'b1, 1'b0);
    do_op(2'b01, 32'd5, 32'd6, 4, 0, 1'b0, 1'b1);

    // A flushed request in IDLE must not be accepted.
    req_valid = 1'b1; flush = 1'b1; req_op = 2'b00;
    #1 chk("stall_idle_flush", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    chk("no_accept_on_flush", 64'(busy), 64'd0);
    req_valid = 1'b0; flush = 1'b0;

    for (int i = 0; i < 30; i++) begin
      op  = 2'($urandom_range(0, 3));
      s1  = $urandom;
      s2  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (op == 2'b10 && s1 == 32'h8000_0000 && s2 == 32'hFFFF_FFFF) s2 = 32'd1;
      lat = $urandom_range(1, 45);
      fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
      do_op(op, s1, s2, lat, fl, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
    end

    do_op(2'b00, 32'd7, 32'd9, 100, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a divide, then an immediate multu.
    req_valid = 1'b1; req_op = 2'b11; req_src1 = 32'd1000; req_src2 = 32'd3;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #3;
    resetn = 1'b0; req_valid = 1'b0; exp_to = 1'b0;
    #1;
    chk("arst_div_start", 64'(div_start), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_stall", 64'(stall_req), 64'd0);
    chk("arst_we", 64'(hilo_we), 64'd0);
    chk("arst_div_op1", 64'(div_op1), 64'd0);
    chk("arst_timeout", 64'(timeout_err), 64'd0);
    #1;
    resetn = 1'b1;
    req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'd11; req_src2 = 32'd13;
    @(posedge clk); #1;
    chk("post_rst_mul_start", 64'(mul_start), 64'd1);
    chk("post_rst_mul_signed", 64'(mul_signed), 64'd0);
    chk("post_rst_mul_op1", 64'(mul_op1), 64'd11);
    flush = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("post_rst_flushed", 64'(busy), 64'd0);

    do_op(2'b11, 32'd100, 32'd7, 5, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
